pellet_renderer: RTL and testbench
==================================

# pellet_renderer

Read-side counterpart of the pellet controller. Takes the live 64-bit pellet map, snapshots it once per frame at vertical blank, and turns VGA pixel coordinates into a pellet-pixel flag through a 2-stage pipeline. After each snapshot, a 64-cycle serial scan counts the remaining pellets and flags level completion to the game FSM.

## Interface
Parameters:
- TILE_W, 80, tile width in pixels (8 columns × 80 = 640)
- TILE_H, 60, tile height in pixels (8 rows × 60 = 480)
- PELLET_SIZE, 8, side of the square pellet in pixels; even and less than both TILE_W and TILE_H

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous, active-low reset
- pellet_arr  in  [0:63]  live pellet map; bit index = row*8 + col; bit 0 is row 0, col 0
- hcount  in  10  current pixel column
- vcount  in  10  current pixel row
- video_on  in  1  pixel lies in the 640×480 active area
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- pellet_px  out  1  pixel at (hcount, vcount) from 2 cycles earlier is a pellet pixel
- px_valid  out  1  video_on delayed 2 cycles
- pellets_left  out  7  pellet count from the most recent completed scan (0–64)
- level_clear  out  1  most recent completed scan found 0 pellets
- count_done  out  1  one-cycle pulse when a scan completes

## Operation
- Snapshot register, snap[0:63]:
  - Loaded from pellet_arr on any clock where frame_start = 1.
  - Held otherwise.
  - Rendering and counting use only snap, which gives tear-free frames.
- Stage 1 (registered every clk):
  - col = number of k in 1..7 with hcount ≥ k*TILE_W. Comparison chain, no divider.
  - row = number of k in 1..7 with vcount ≥ k*TILE_H.
  - x_off = hcount − col*TILE_W; y_off = vcount − row*TILE_H.
  - Register row, col, x_off, y_off and video_on.
- Stage 2 (registered every clk):
  - Compute in_sq as follows:
    - x_off is in [TILE_W/2 − PELLET_SIZE/2, TILE_W/2 + PELLET_SIZE/2 − 1]. With defaults this is 36..43.
    - y_off is in [TILE_H/2 − PELLET_SIZE/2, TILE_H/2 + PELLET_SIZE/2 − 1]. With defaults this is 26..33.
  - pellet_px ← stage1.video_on & snap[row*8+col] & in_sq.
  - px_valid ← stage1.video_on.
  - When video_on = 0, pellet_px = 0 regardless of coordinates. This includes hcount ≥ 640.
- Counter FSM, states IDLE and COUNT:
  - IDLE, frame_start = 1:
    - Load snap.
    - idx ← 0, acc ← 0.
    - Go to COUNT.
  - COUNT: each clk, acc ← acc + snap[idx] and idx ← idx + 1.
  - COUNT at idx = 63:
    - pellets_left ← acc + snap[63].
    - level_clear ← (acc + snap[63] == 0).
    - count_done ← 1 for one cycle.
    - Go to IDLE.
  - frame_start during COUNT:
    - Reload snap and restart: idx ← 0, acc ← 0.
    - Stay in COUNT.
    - No count_done is produced for the aborted scan.
    - pellets_left and level_clear keep their previous values.
  - acc is 7 bits wide; the maximum value 64 fits without wrap.

## Timing
- Reset values (asynchronous, while rst_n = 0):
  - snap = 0, state = IDLE, idx = 0, acc = 0.
  - pellet_px = 0, px_valid = 0.
  - pellets_left = 0, level_clear = 0, count_done = 0.
- Consequences of reset:
  - No pellets render until the first frame_start.
  - level_clear is never asserted before the first completed scan.
- Pixel latency: exactly 2 clocks from hcount/vcount/video_on to pellet_px/px_valid. The pipeline runs continuously and has no stall.
- Snapshot update: with frame_start at cycle 0, snap holds the new value from cycle 1. Pixels presented on cycle ≥ 1 use the new map.
- Scan timing: with frame_start at cycle 0:
  - COUNT occupies cycles 1..64.
  - count_done is high in cycle 65.
  - pellets_left and level_clear are valid from cycle 65 and held until the next completed scan.
- pellet_arr changes between frame_start pulses do not affect any output.
- Reset asserted mid-scan aborts the scan immediately and returns all outputs to their reset values.

## Test plan
- Reset: hold rst_n = 0 with random inputs. All outputs must be 0. Release reset and drive no frame_start: pellet_px must stay 0 for all pixels.
- Pixel hit: pellet_arr bit 9 set (row 1, col 1), pulse frame_start, then drive hcount = 116, vcount = 86, video_on = 1. pellet_px must be 1 two cycles later. hcount = 115 or 124 must give 0, and video_on = 0 must give 0.
- Snapshot isolation: after the pixel-hit test, clear bit 9 in pellet_arr without a frame_start. Pixel (116, 86) must still give 1. After a frame_start it must give 0.
- Maze count: load the power-on maze (rows 1–6 contain 4, 2, 6, 2, 2, 6 pellets) and pulse frame_start at cycle 0. count_done must be high in cycle 65 only, pellets_left = 22, level_clear = 0.
- Empty map: pellet_arr = 0 with frame_start. In cycle 65, pellets_left = 0, level_clear = 1, count_done = 1.
- Restart: with pellet_arr = all ones, pulse frame_start at cycle 0 and again at cycle 30. There must be no count_done at cycle 65. count_done must appear at cycle 95 with pellets_left = 64.

Source files
------------

// File: rtl/pellet_renderer_if.sv
// Pellet renderer bus: live map and pixel coordinates in, pellet flag and scan results out.
interface pellet_renderer_if;
  logic [0:63] pellet_arr;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        video_on;
  logic        frame_start;
  logic        pellet_px;
  logic        px_valid;
  logic [6:0]  pellets_left;
  logic        level_clear;
  logic        count_done;

  modport master (
    output pellet_arr, hcount, vcount, video_on, frame_start,
    input  pellet_px, px_valid, pellets_left, level_clear, count_done
  );

  modport slave (
    input  pellet_arr, hcount, vcount, video_on, frame_start,
    output pellet_px, px_valid, pellets_left, level_clear, count_done
  );
endinterface

// File: rtl/pellet_renderer.sv
// Snapshots the pellet map per frame, renders pellet pixels through a 2-stage pipeline and
// serially counts the remaining pellets after every snapshot.
module pellet_renderer #(
  parameter int unsigned TILE_W      = 80,
  parameter int unsigned TILE_H      = 60,
  parameter int unsigned PELLET_SIZE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pellet_renderer_if.slave  bus
);

  localparam logic [9:0] XLo = 10'(TILE_W / 2 - PELLET_SIZE / 2);
  localparam logic [9:0] XHi = 10'(TILE_W / 2 + PELLET_SIZE / 2 - 1);
  localparam logic [9:0] YLo = 10'(TILE_H / 2 - PELLET_SIZE / 2);
  localparam logic [9:0] YHi = 10'(TILE_H / 2 + PELLET_SIZE / 2 - 1);

  typedef enum logic [0:0] {StIdle, StCount} state_e;

  logic [0:63] snap_q;
  state_e      state_q;
  logic [5:0]  idx_q;
  logic [6:0]  acc_q;
  logic [6:0]  pellets_left_q;
  logic        level_clear_q;
  logic        count_done_q;

  logic [2:0]  col_c, row_c, col_q, row_q;
  logic [9:0]  x_base, y_base, x_off_q, y_off_q;
  logic        von_q;
  logic        pellet_px_q, px_valid_q;
  logic        in_sq;
  logic [6:0]  final_cnt;

  // Monotone comparison chain: the last threshold passed gives the tile index and origin.
  always_comb begin
    col_c  = '0;
    row_c  = '0;
    x_base = '0;
    y_base = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (bus.hcount >= 10'(k * TILE_W)) begin
        col_c  = 3'(k);
        x_base = 10'(k * TILE_W);
      end
      if (bus.vcount >= 10'(k * TILE_H)) begin
        row_c  = 3'(k);
        y_base = 10'(k * TILE_H);
      end
    end
  end

  always_comb begin
    in_sq     = (x_off_q >= XLo) && (x_off_q <= XHi) && (y_off_q >= YLo) && (y_off_q <= YHi);
    final_cnt = acc_q + {6'd0, snap_q[63]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      x_off_q     <= '0;
      y_off_q     <= '0;
      von_q       <= 1'b0;
      pellet_px_q <= 1'b0;
      px_valid_q  <= 1'b0;
    end else begin
      col_q       <= col_c;
      row_q       <= row_c;
      x_off_q     <= bus.hcount - x_base;
      y_off_q     <= bus.vcount - y_base;
      von_q       <= bus.video_on;
      pellet_px_q <= von_q & snap_q[{row_q, col_q}] & in_sq;
      px_valid_q  <= von_q;
    end
  end

  // A frame_start always reloads the snapshot and (re)starts the scan, even mid-count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q         <= '0;
      state_q        <= StIdle;
      idx_q          <= '0;
      acc_q          <= '0;
      pellets_left_q <= '0;
      level_clear_q  <= 1'b0;
      count_done_q   <= 1'b0;
    end else begin
      count_done_q <= 1'b0;
      if (bus.frame_start) begin
        snap_q  <= bus.pellet_arr;
        idx_q   <= '0;
        acc_q   <= '0;
        state_q <= StCount;
      end else begin
        unique case (state_q)
          StIdle: ;
          StCount: begin
            if (idx_q == 6'd63) begin
              pellets_left_q <= final_cnt;
              level_clear_q  <= (final_cnt == 7'd0);
              count_done_q   <= 1'b1;
              state_q        <= StIdle;
            end else begin
              acc_q <= acc_q + {6'd0, snap_q[idx_q]};
              idx_q <= idx_q + 6'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.pellet_px    = pellet_px_q;
  assign bus.px_valid     = px_valid_q;
  assign bus.pellets_left = pellets_left_q;
  assign bus.level_clear  = level_clear_q;
  assign bus.count_done   = count_done_q;

endmodule

// File: tb/tb_pellet_renderer.sv
// Directed bench for pellet_renderer: reset, pixel hits/misses, snapshot isolation and scans.
module tb_pellet_renderer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  pellet_renderer_if bus ();

  pellet_renderer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 relative to the pulse.
  task automatic pulse();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic pixel(input logic [9:0] h, input logic [9:0] v, input logic von,
                       output logic p, output logic vld);
    bus.hcount   = h;
    bus.vcount   = v;
    bus.video_on = von;
    tick();
    tick();
    p   = bus.pellet_px;
    vld = bus.px_valid;
  endtask

  // Called in cycle 1 after the (last) frame_start; checks cycles 1..66.
  task automatic scan_check(input string tag, input logic [6:0] exp_left, input logic exp_clr);
    int early;
    early = 0;
    repeat (64) begin
      if (bus.count_done) early++;
      tick();
    end
    check({tag, "_no_early_done"}, early, 0);
    check({tag, "_done"}, bus.count_done, 1);
    check({tag, "_left"}, bus.pellets_left, exp_left);
    check({tag, "_clear"}, bus.level_clear, exp_clr);
    tick();
    check({tag, "_done_one_cycle"}, bus.count_done, 0);
  endtask

  logic [63:0] rnd;
  logic        p, vld;
  int          hits, early;

  initial begin
    bus.pellet_arr  = '0;
    bus.hcount      = '0;
    bus.vcount      = '0;
    bus.video_on    = 1'b0;
    bus.frame_start = 1'b0;

    // Reset held with random inputs.
    repeat (4) begin
      rnd             = {$urandom, $urandom};
      bus.pellet_arr  = rnd;
      bus.hcount      = 10'($urandom_range(0, 1023));
      bus.vcount      = 10'($urandom_range(0, 1023));
      bus.video_on    = 1'($urandom);
      bus.frame_start = 1'($urandom);
      tick();
    end
    check("rst_pellet_px", bus.pellet_px, 0);
    check("rst_px_valid", bus.px_valid, 0);
    check("rst_pellets_left", bus.pellets_left, 0);
    check("rst_level_clear", bus.level_clear, 0);
    check("rst_count_done", bus.count_done, 0);

    // No frame_start after reset: every pellet centre stays dark.
    bus.frame_start = 1'b0;
    bus.pellet_arr  = '1;
    rst_n = 1'b1;
    hits = 0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        pixel(10'(c * 80 + 40), 10'(r * 60 + 30), 1'b1, p, vld);
        if (p) hits++;
      end
    end
    check("no_render_before_snap", hits, 0);
    check("post_rst_level_clear", bus.level_clear, 0);

    // Pixel hit on row 1, col 1.
    bus.pellet_arr    = '0;
    bus.pellet_arr[9] = 1'b1;
    pulse();
    pixel(10'd116, 10'd86, 1'b1, p, vld);
    check("hit_116_86", p, 1);
    check("hit_valid", vld, 1);
    pixel(10'd115, 10'd86, 1'b1, p, vld);
    check("miss_115", p, 0);
    pixel(10'd124, 10'd86, 1'b1, p, vld);
    check("miss_124", p, 0);
    pixel(10'd123, 10'd93, 1'b1, p, vld);
    check("hit_123_93", p, 1);
    pixel(10'd116, 10'd94, 1'b1, p, vld);
    check("miss_v94", p, 0);
    pixel(10'd116, 10'd86, 1'b0, p, vld);
    check("blank_px", p, 0);
    check("blank_valid", vld, 0);
    pixel(10'd196, 10'd86, 1'b1, p, vld);
    check("miss_other_tile", p, 0);

    // Snapshot isolation.
    bus.pellet_arr[9] = 1'b0;
    pixel(10'd116, 10'd86, 1'b1, p, vld);
    check("iso_held", p, 1);
    pulse();
    pixel(10'd116, 10'd86, 1'b1, p, vld);
    check("iso_reloaded", p, 0);
    bus.video_on = 1'b0;
    repeat (70) tick();

    // Power-on maze: 4,2,6,2,2,6 pellets in rows 1..6.
    bus.pellet_arr = '0;
    for (int c = 1; c <= 6; c++) begin
      bus.pellet_arr[3 * 8 + c] = 1'b1;
      bus.pellet_arr[6 * 8 + c] = 1'b1;
    end
    for (int r = 2; r <= 5; r++) begin
      bus.pellet_arr[r * 8 + 1] = 1'b1;
      bus.pellet_arr[r * 8 + 6] = 1'b1;
    end
    bus.pellet_arr[1 * 8 + 2] = 1'b1;
    bus.pellet_arr[1 * 8 + 5] = 1'b1;
    bus.pellet_arr[1 * 8 + 1] = 1'b1;
    bus.pellet_arr[1 * 8 + 6] = 1'b1;
    pulse();
    scan_check("maze", 7'd22, 1'b0);

    // Empty map.
    bus.pellet_arr = '0;
    pulse();
    scan_check("empty", 7'd0, 1'b1);

    // Restart mid-scan with a full map.
    bus.pellet_arr = '1;
    pulse();
    early = 0;
    repeat (29) begin
      if (bus.count_done) early++;
      tick();
    end
    check("restart_first_no_done", early, 0);
    check("restart_left_held", bus.pellets_left, 0);
    check("restart_clear_held", bus.level_clear, 1);
    pulse();
    scan_check("restart", 7'd64, 1'b0);

    // Reset in the middle of a scan.
    pulse();
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_left", bus.pellets_left, 0);
    check("midrst_clear", bus.level_clear, 0);
    check("midrst_done", bus.count_done, 0);
    tick();
    rst_n = 1'b1;
    repeat (70) tick();
    check("midrst_no_done_after", bus.count_done, 0);
    check("midrst_left_after", bus.pellets_left, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
